// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes an RV32 subset into ALU controls, registers the
// result for the EX stage, and inserts a one-cycle bubble on load-use hazards.
module id_ex_alu_issue #(
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        branch_ne,
    output logic [31:0] store_data,
    output logic        illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dst;
    logic [31:0] imm_i;
    logic [31:0] imm_s;

    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_rd;
    logic        dec_rw;
    logic        dec_mr;
    logic        dec_mw;
    logic        dec_br;
    logic        dec_bne;
    logic [31:0] dec_sd;
    logic        uses_rs1;
    logic        uses_rs2;

    logic        hazard;
    logic        transfer;

    // The PC travels with the instruction but branch targets are formed
    // elsewhere, so it is deliberately consumed here without effect.
    logic        unused_pc;
    assign unused_pc = ^pc;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign src1   = instr[19:15];
    assign src2   = instr[24:20];
    assign dst    = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    // Decode the incoming instruction into EX controls; unknown encodings
    // fall out as an illegal marker with neutral operands.
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_a     = rs1_data;
        dec_b     = rs2_data;
        dec_rw    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_br    = 1'b0;
        dec_bne   = 1'b0;
        dec_sd    = 32'd0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        case (opcode)
            OP_R: begin
                dec_rw   = 1'b1;
                uses_rs2 = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = ALU_SUB;
                        end
                    end
                    3'b111: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_AND;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_OR;
                    end
                    3'b010: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_SLT;
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                dec_rw = 1'b1;
                dec_b  = imm_i;
                case (funct3)
                    3'b000: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_ADD;
                    end
                    3'b111: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_AND;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_OR;
                    end
                    3'b010: begin
                        dec_legal = 1'b1;
                        dec_ctrl  = ALU_SLT;
                    end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                dec_b     = imm_i;
                dec_rw    = 1'b1;
                dec_mr    = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            OP_STORE: begin
                dec_b     = imm_s;
                dec_mw    = 1'b1;
                dec_sd    = rs2_data;
                uses_rs2  = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                dec_ctrl  = ALU_SUB;
                dec_br    = 1'b1;
                dec_bne   = funct3[0];
                uses_rs2  = 1'b1;
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec_ctrl = ALU_ADD;
            dec_a    = 32'd0;
            dec_b    = 32'd0;
            dec_rw   = 1'b0;
            dec_mr   = 1'b0;
            dec_mw   = 1'b0;
            dec_br   = 1'b0;
            dec_bne  = 1'b0;
            dec_sd   = 32'd0;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
        if (dst == 5'd0) begin
            dec_rw = 1'b0;
        end
        dec_rd = dec_legal ? dst : 5'd0;
    end

    // Load-use hazard: the load in EX writes a register the incoming
    // instruction reads, so hold decode for one cycle.
    always_comb begin
        hazard = HAZARD_EN && in_valid && out_valid && mem_read && (rd != 5'd0) &&
                 ((uses_rs1 && (rd == src1)) || (uses_rs2 && (rd == src2)));
        in_ready = !rst && !stall && !flush && !hazard;
        transfer = in_valid && in_ready;
    end

    // EX-stage register: reset, then flush, then stall-hold, then issue,
    // otherwise a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_ctrl   <= ALU_ADD;
            rd         <= 5'd0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            branch_ne  <= 1'b0;
            store_data <= 32'd0;
            illegal    <= 1'b0;
        end else if (flush || (!stall && !transfer)) begin
            out_valid  <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            branch_ne  <= 1'b0;
            illegal    <= 1'b0;
        end else if (transfer) begin
            out_valid  <= 1'b1;
            alu_a      <= dec_a;
            alu_b      <= dec_b;
            alu_ctrl   <= dec_ctrl;
            rd         <= dec_rd;
            reg_write  <= dec_rw;
            mem_read   <= dec_mr;
            mem_write  <= dec_mw;
            branch     <= dec_br;
            branch_ne  <= dec_bne;
            store_data <= dec_sd;
            illegal    <= !dec_legal;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed instructions with
// hand-computed EX-stage expectations, checked by a separate monitor.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        in_ready, out_valid, reg_write, mem_read, mem_write, branch, branch_ne, illegal;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;

    logic        nh_in_ready, nh_out_valid, nh_reg_write, nh_mem_read, nh_mem_write;
    logic        nh_branch, nh_branch_ne, nh_illegal;
    logic [31:0] nh_alu_a, nh_alu_b, nh_store_data;
    logic [3:0]  nh_alu_ctrl;
    logic [4:0]  nh_rd;

    id_ex_alu_issue #(.HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush), .out_valid(out_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .branch_ne(branch_ne), .store_data(store_data),
        .illegal(illegal)
    );

    id_ex_alu_issue #(.HAZARD_EN(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nh_in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush), .out_valid(nh_out_valid),
        .alu_a(nh_alu_a), .alu_b(nh_alu_b), .alu_ctrl(nh_alu_ctrl), .rd(nh_rd),
        .reg_write(nh_reg_write), .mem_read(nh_mem_read), .mem_write(nh_mem_write),
        .branch(nh_branch), .branch_ne(nh_branch_ne), .store_data(nh_store_data),
        .illegal(nh_illegal)
    );

    always #5 clk = ~clk;

    // Hand-encoded instructions
    localparam logic [31:0] I_ADD_3_1_2  = 32'h002081B3;
    localparam logic [31:0] I_ADDI_0_1_M1 = 32'hFFF08013;
    localparam logic [31:0] I_SW_2_M4    = 32'hFE20AE23;
    localparam logic [31:0] I_LW_5_8     = 32'h0080A283;
    localparam logic [31:0] I_ADD_6_5_1  = 32'h00128333;
    localparam logic [31:0] I_SUB_7_1_2  = 32'h402083B3;
    localparam logic [31:0] I_BNE_1_2    = 32'h00209063;
    localparam logic [31:0] I_AND_8_1_2  = 32'h0020F433;
    localparam logic [31:0] I_ORI_9_F0   = 32'h0F00E493;
    localparam logic [31:0] I_SLT_10_1_2 = 32'h0020A533;
    localparam logic [31:0] I_SW_5_0     = 32'h0050A023;
    localparam logic [31:0] I_ADDI_6_1_5 = 32'h00508313;
    localparam logic [31:0] I_BAD        = 32'hFFFFFFFF;

    typedef struct {
        int          cyc;
        int          step;
        logic        full;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, bne;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    exp_t sb_queue[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   step = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t mk_full(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] ctrl, input logic [4:0] r,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic br, input logic bne,
                                     input logic [31:0] sd, input logic ill);
        exp_t e;
        e.cyc = 0; e.step = 0; e.full = 1'b1; e.valid = 1'b1;
        e.a = a; e.b = b; e.ctrl = ctrl; e.rd = r;
        e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.bne = bne;
        e.sd = sd; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t mk_reset();
        exp_t e;
        e = mk_full(32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        e.valid = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk_bubble();
        exp_t e;
        e = mk_reset();
        e.full = 1'b0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue what EX must hold after the next edge,
    // and check the combinational ready.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic f,
                                 input logic exp_ready, input exp_t e);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        instr    = ins;
        pc       = 32'h0000_1000 + 32'(step) * 32'd4;
        rs1_data = a;
        rs2_data = b;
        stall    = s;
        flush    = f;
        e.cyc    = cycle + 1;
        e.step   = step;
        sb_queue.push_back(e);
        #1;
        checkOutput($sformatf("step %0d in_ready", step), {31'd0, in_ready}, {31'd0, exp_ready});
        step++;
    endtask

    // Monitor: compare EX-stage outputs against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_queue.size() > 0 && sb_queue[0].cyc <= cycle) begin
                mon_e = sb_queue.pop_front();
                checkOutput($sformatf("step %0d timing", mon_e.step), 32'(mon_e.cyc), 32'(cycle));
                checkOutput($sformatf("step %0d out_valid", mon_e.step), {31'd0, out_valid}, {31'd0, mon_e.valid});
                checkOutput($sformatf("step %0d controls", mon_e.step),
                            {26'd0, reg_write, mem_read, mem_write, branch, branch_ne, illegal},
                            {26'd0, mon_e.rw, mon_e.mr, mon_e.mw, mon_e.br, mon_e.bne, mon_e.ill});
                if (mon_e.full) begin
                    checkOutput($sformatf("step %0d alu_a", mon_e.step), alu_a, mon_e.a);
                    checkOutput($sformatf("step %0d alu_b", mon_e.step), alu_b, mon_e.b);
                    checkOutput($sformatf("step %0d alu_ctrl", mon_e.step), {28'd0, alu_ctrl}, {28'd0, mon_e.ctrl});
                    checkOutput($sformatf("step %0d rd", mon_e.step), {27'd0, rd}, {27'd0, mon_e.rd});
                    checkOutput($sformatf("step %0d store_data", mon_e.step), store_data, mon_e.sd);
                end
            end
        end
    end

    exp_t e_add3, e_sub7, e_lw5, e_add6;

    // Directed stimulus sequence
    initial begin
        e_add3 = mk_full(32'd5, 32'd7, 4'b0010, 5'd3, 1, 0, 0, 0, 0, 32'd0, 0);
        e_sub7 = mk_full(32'd50, 32'd8, 4'b0110, 5'd7, 1, 0, 0, 0, 0, 32'd0, 0);
        e_lw5  = mk_full(32'h40, 32'd8, 4'b0010, 5'd5, 1, 1, 0, 0, 0, 32'd0, 0);
        e_add6 = mk_full(32'd11, 32'd22, 4'b0010, 5'd6, 1, 0, 0, 0, 0, 32'd0, 0);

        // Reset overrides a presented transfer
        applyStimulus(1, 1, I_ADD_3_1_2, 32'd5, 32'd7, 0, 0, 0, mk_reset());
        applyStimulus(1, 1, I_ADD_3_1_2, 32'd5, 32'd7, 1, 1, 0, mk_reset());

        // Decode coverage
        applyStimulus(0, 1, I_ADD_3_1_2, 32'd5, 32'd7, 0, 0, 1, e_add3);
        applyStimulus(0, 1, I_SW_2_M4, 32'h100, 32'hDEADBEEF, 0, 0, 1,
                      mk_full(32'h100, 32'hFFFFFFFC, 4'b0010, 5'd28, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0));
        applyStimulus(0, 1, I_ADDI_0_1_M1, 32'd3, 32'd9, 0, 0, 1,
                      mk_full(32'd3, 32'hFFFFFFFF, 4'b0010, 5'd0, 0, 0, 0, 0, 0, 32'd0, 0));
        applyStimulus(0, 1, I_AND_8_1_2, 32'hF0F0, 32'hFF00, 0, 0, 1,
                      mk_full(32'hF0F0, 32'hFF00, 4'b0000, 5'd8, 1, 0, 0, 0, 0, 32'd0, 0));
        applyStimulus(0, 1, I_ORI_9_F0, 32'd1, 32'd2, 0, 0, 1,
                      mk_full(32'd1, 32'hF0, 4'b0001, 5'd9, 1, 0, 0, 0, 0, 32'd0, 0));
        applyStimulus(0, 1, I_SLT_10_1_2, 32'hFFFFFFFF, 32'd1, 0, 0, 1,
                      mk_full(32'hFFFFFFFF, 32'd1, 4'b0111, 5'd10, 1, 0, 0, 0, 0, 32'd0, 0));
        applyStimulus(0, 1, I_BNE_1_2, 32'd4, 32'd9, 0, 0, 1,
                      mk_full(32'd4, 32'd9, 4'b0110, 5'd0, 0, 0, 0, 1, 1, 32'd0, 0));
        applyStimulus(0, 1, I_BAD, 32'd4, 32'd9, 0, 0, 1,
                      mk_full(32'd0, 32'd0, 4'b0010, 5'd0, 0, 0, 0, 0, 0, 32'd0, 1));
        applyStimulus(0, 0, I_ADD_3_1_2, 32'd5, 32'd7, 0, 0, 1, mk_bubble());

        // Load-use on rs1: one bubble, then the consumer issues
        applyStimulus(0, 1, I_LW_5_8, 32'h40, 32'd0, 0, 0, 1, e_lw5);
        applyStimulus(0, 1, I_ADD_6_5_1, 32'd11, 32'd22, 0, 0, 0, mk_bubble());
        checkOutput("nohaz in_ready", {31'd0, nh_in_ready}, 32'd1);
        applyStimulus(0, 1, I_ADD_6_5_1, 32'd11, 32'd22, 0, 0, 1, e_add6);
        checkOutput("nohaz out_valid", {31'd0, nh_out_valid}, 32'd1);
        checkOutput("nohaz rd", {27'd0, nh_rd}, 32'd6);
        checkOutput("nohaz alu_a", nh_alu_a, 32'd11);

        // Stall holds SUB for three cycles, then stall+flush and flush alone
        applyStimulus(0, 1, I_SUB_7_1_2, 32'd50, 32'd8, 0, 0, 1, e_sub7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, I_AND_8_1_2, 32'd1, 32'd2, 1, 0, 0, e_sub7);
        end
        applyStimulus(0, 1, I_AND_8_1_2, 32'd1, 32'd2, 1, 1, 0, mk_bubble());
        applyStimulus(0, 1, I_AND_8_1_2, 32'd1, 32'd2, 0, 1, 0, mk_bubble());

        // Load-use on rs2 of a store; I-type immediate field must not alias rs2
        applyStimulus(0, 1, I_LW_5_8, 32'h40, 32'd0, 0, 0, 1, e_lw5);
        applyStimulus(0, 1, I_SW_5_0, 32'h80, 32'h55, 0, 0, 0, mk_bubble());
        applyStimulus(0, 1, I_SW_5_0, 32'h80, 32'h55, 0, 0, 1,
                      mk_full(32'h80, 32'd0, 4'b0010, 5'd0, 0, 0, 1, 0, 0, 32'h55, 0));
        applyStimulus(0, 1, I_LW_5_8, 32'h40, 32'd0, 0, 0, 1, e_lw5);
        applyStimulus(0, 1, I_ADDI_6_1_5, 32'd20, 32'd0, 0, 0, 1,
                      mk_full(32'd20, 32'd5, 4'b0010, 5'd6, 1, 0, 0, 0, 0, 32'd0, 0));

        // Reset mid-hazard discards the bubble; consumer issues right after
        applyStimulus(0, 1, I_LW_5_8, 32'h40, 32'd0, 0, 0, 1, e_lw5);
        applyStimulus(1, 1, I_ADD_6_5_1, 32'd11, 32'd22, 0, 0, 0, mk_reset());
        applyStimulus(0, 1, I_ADD_6_5_1, 32'd11, 32'd22, 0, 0, 1, e_add6);

        // Reset one cycle after a transfer
        applyStimulus(0, 1, I_ADD_3_1_2, 32'd5, 32'd7, 0, 0, 1, e_add3);
        applyStimulus(1, 1, I_SUB_7_1_2, 32'd50, 32'd8, 0, 0, 0, mk_reset());
        applyStimulus(0, 0, I_SUB_7_1_2, 32'd50, 32'd8, 0, 0, 1, mk_bubble());

        for (int i = 0; i < 20 && sb_queue.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (sb_queue.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb_queue.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
